zap_wb_arbiter: RTL and testbench
=================================

# zap_wb_arbiter

Round-robin Wishbone B3 arbiter that shares the SoC data bus between several bus masters: the ZAP CPU data port and the EthMAC DMA master. Sits between the masters and the existing address-decode fabric. Holds a grant for the whole `cyc` envelope, so bursts are atomic. A watchdog terminates any transfer that a slave never acknowledges.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); master 0 = CPU, master 1 = EthMAC
- TIMEOUT, 255, max cycles a strobed beat may wait for ack/err before forced error (1..65535)

Ports (master-side buses flattened, master k at slice [k*W +: W]):
- i_clk  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_mst_cyc  in  NUM_MASTERS  per-master cyc
- i_mst_stb  in  NUM_MASTERS  per-master stb
- i_mst_we  in  NUM_MASTERS  per-master write enable
- i_mst_adr  in  32*NUM_MASTERS  per-master address
- i_mst_dat  in  32*NUM_MASTERS  per-master write data
- i_mst_sel  in  4*NUM_MASTERS  per-master byte select
- i_mst_cti  in  3*NUM_MASTERS  per-master cycle type
- o_mst_ack  out  NUM_MASTERS  ack, routed to granted master only
- o_mst_err  out  NUM_MASTERS  err, routed to granted master only
- o_mst_dat  out  32  read data, broadcast to all masters
- o_slv_cyc, o_slv_stb, o_slv_we  out  1  to fabric
- o_slv_adr, o_slv_dat  out  32  to fabric
- o_slv_sel  out  4  to fabric
- o_slv_cti  out  3  to fabric
- i_slv_ack, i_slv_err  in  1  from fabric
- i_slv_dat  in  32  from fabric
- o_grant  out  NUM_MASTERS  one-hot current grant, all-zero when idle
- o_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- States:
  - IDLE: no grant.
  - BUSY: the granted master owns the bus.
  - ERR: a forced error is being returned.
  - DRAIN: waiting for the timed-out master to release.
- IDLE:
  - If any i_mst_cyc is high, pick a winner round-robin starting at (last+1) mod NUM_MASTERS.
  - Register the winner into grant and last; go to BUSY.
- BUSY:
  - o_slv_* = granted master's signals.
  - o_mst_ack[g] = i_slv_ack and o_mst_err[g] = i_slv_err; all other masters see 0.
  - Granted master's cyc low at the clock edge → IDLE (grant cleared). Requests from other masters during BUSY wait.
- Watchdog:
  - Counter clears on entry to BUSY and whenever i_slv_ack or i_slv_err is high.
  - Increments each BUSY cycle with o_slv_stb high and no ack/err.
  - At count == TIMEOUT-1 with no ack/err, go to ERR.
- ERR (exactly 1 cycle):
  - o_slv_cyc = o_slv_stb = 0; o_mst_err[g] = 1; o_timeout = 1.
  - Next state: DRAIN.
- DRAIN:
  - Slave side held idle; no ack/err to anyone.
  - When granted master's cyc is low → IDLE.
- Ungranted masters never receive ack/err.
- Reset (async, any state):
  - State IDLE, grant 0, counter 0; last = NUM_MASTERS-1, so master 0 wins first.
  - All outputs 0.
  - A transfer in flight is abandoned; the slave sees cyc drop immediately.

## Timing
- Arbitration latency: master asserts cyc in cycle t → o_slv_cyc high in cycle t+1.
- Slave→master ack/err/data path is combinational, zero added latency per beat.
- Master→slave path is a combinational mux on the registered grant.
- Release: cyc low at edge e → IDLE at e; a new grant is registered at e+1. So there is a minimum one dead cycle between owners, and the same master may re-win only if no other master requests.
- Simultaneous requests in IDLE: lowest index at or after last+1 wins. With two masters both requesting continuously, grants strictly alternate.
- Timeout: ERR is entered TIMEOUT cycles after the last ack/err (or after stb first asserted).
- ack arriving in the same cycle the count reaches TIMEOUT-1 wins: the beat is acknowledged and no error is raised.
- Slave ack/err during ERR/DRAIN is ignored.

## Structure
- Shared package zap_wb_pkg holds:
  - Wishbone CTI encodings (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111).
  - Arbiter state encoding.
  - Master index constants CPU_MST=0, ETH_MST=1.
- One sub-module, zap_rr_pick: combinational round-robin picker (request vector, last index → one-hot winner + index). It is reusable by the VIC priority path later.

## Test plan
- Single CPU classic read, slave acks after 2 cycles, i_slv_dat=32'hDEADBEEF:
  - o_grant=01 one cycle after cyc.
  - o_mst_ack[0] pulses once with o_mst_dat=DEADBEEF.
  - Grant=00 one cycle after cyc drops.
- Both masters assert cyc in the same cycle from reset:
  - Master 0 granted first.
  - After it releases, master 1 granted.
  - Repeated for 8 transactions: grant order 0,1,0,1,...
- EthMAC 4-beat INCR burst (cti 010,010,010,111) while CPU requests mid-burst:
  - All 4 beats complete on master 1 with no interleave.
  - CPU granted two cycles after master 1 drops cyc.
- TIMEOUT=8, slave never acks:
  - o_mst_err[0] and o_timeout high exactly 8 cycles after stb, for 1 cycle.
  - o_slv_cyc low from then.
  - Grant held until master 0 drops cyc.
- Slave acks on cycle TIMEOUT-1: ack delivered, no err, no o_timeout.
- Assert i_reset_n low mid-burst:
  - All outputs 0 asynchronously.
  - After release, a simultaneous request from both masters grants master 0.

Source files
------------

// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg
// Shared definitions for the ZAP Wishbone data-bus fabric.
//   - Wishbone B3 cycle-type (CTI) encodings
//   - arbiter state encoding
//   - fixed master index assignments on the shared data bus
package zap_wb_pkg;

   // Wishbone B3 cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Master slots on the shared data bus
   localparam int CPU_MST = 0;
   localparam int ETH_MST = 1;

   // Arbiter states
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_ERR   = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_e;

endpackage

// File: rtl/zap_rr_pick.sv
// zap_rr_pick
// Combinational round-robin picker. Given a request vector and the index
// of the previous winner, selects the lowest-indexed requester strictly
// above last_i, wrapping to the lowest-indexed requester overall.
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   last_i  [IDX_W-1:0]    index of the previous winner
//   gnt_o   [NUM_REQ-1:0]  one-hot winner (all zero when no request)
//   idx_o   [IDX_W-1:0]    winner index (0 when no request)
//   valid_o                at least one request present
module zap_rr_pick
   import zap_wb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // Two descending scans so the last write wins: the first finds the
   // lowest requester overall (the wrap-around case), the second overrides
   // it with the lowest requester above the previous winner if one exists.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = |req_i;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i] && (i > int'(last_i))) begin
            idx_o = IDX_W'(i);
         end
      end
      if (valid_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter
// Round-robin Wishbone B3 arbiter sharing the SoC data bus between the
// ZAP CPU data port (master 0), the EthMAC DMA (master 1) and optional
// further masters. A grant is held for the whole cyc envelope so bursts
// stay atomic; a watchdog forces an error on beats that are never acked.
// Ports:
//   i_clk, i_reset_n             clock, async active-low reset
//   i_mst_*                      flattened master buses, master k at [k*W +: W]
//   o_mst_ack, o_mst_err         per-master termination, granted master only
//   o_mst_dat                    read data broadcast while a master owns the bus
//   o_slv_*                      muxed request towards the decode fabric
//   i_slv_ack, i_slv_err, i_slv_dat  response from the fabric
//   o_grant                      one-hot current owner, zero when idle
//   o_timeout                    one-cycle pulse when the watchdog fires
module zap_wb_arbiter
   import zap_wb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NUM_MASTERS-1:0]    i_mst_cyc,
   input  logic [NUM_MASTERS-1:0]    i_mst_stb,
   input  logic [NUM_MASTERS-1:0]    i_mst_we,
   input  logic [32*NUM_MASTERS-1:0] i_mst_adr,
   input  logic [32*NUM_MASTERS-1:0] i_mst_dat,
   input  logic [4*NUM_MASTERS-1:0]  i_mst_sel,
   input  logic [3*NUM_MASTERS-1:0]  i_mst_cti,
   output logic [NUM_MASTERS-1:0]    o_mst_ack,
   output logic [NUM_MASTERS-1:0]    o_mst_err,
   output logic [31:0]               o_mst_dat,
   output logic                      o_slv_cyc,
   output logic                      o_slv_stb,
   output logic                      o_slv_we,
   output logic [31:0]               o_slv_adr,
   output logic [31:0]               o_slv_dat,
   output logic [3:0]                o_slv_sel,
   output logic [2:0]                o_slv_cti,
   input  logic                      i_slv_ack,
   input  logic                      i_slv_err,
   input  logic [31:0]               i_slv_dat,
   output logic [NUM_MASTERS-1:0]    o_grant,
   output logic                      o_timeout
);

   localparam int          IDX_W   = $clog2(NUM_MASTERS);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   arb_state_e             state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [IDX_W-1:0]       last_q;
   logic [15:0]            count_q;

   logic [NUM_MASTERS-1:0] winGnt_d;
   logic [IDX_W-1:0]       winIdx_d;
   logic                   winValid;
   logic                   grantCyc;
   logic                   slvTerm;

   zap_rr_pick #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (i_mst_cyc),
      .last_i  (last_q),
      .gnt_o   (winGnt_d),
      .idx_o   (winIdx_d),
      .valid_o (winValid)
   );

   assign grantCyc  = |(i_mst_cyc & grant_q);
   assign slvTerm   = i_slv_ack | i_slv_err;
   assign o_grant   = grant_q;
   assign o_timeout = (state_q == ARB_ERR);

   // Arbitration FSM with watchdog. The counter holds between strobes so
   // the timeout measures stalled strobed cycles since the last ack/err.
   // The ack/err test comes first so a response in the final watchdog
   // cycle completes the beat instead of raising an error.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
         count_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (winValid) begin
                  grant_q <= winGnt_d;
                  last_q  <= winIdx_d;
                  count_q <= '0;
                  state_q <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (!grantCyc) begin
                  grant_q <= '0;
                  count_q <= '0;
                  state_q <= ARB_IDLE;
               end else if (slvTerm) begin
                  count_q <= '0;
               end else if (o_slv_stb) begin
                  if (count_q == TO_LAST) begin
                     count_q <= '0;
                     state_q <= ARB_ERR;
                  end else begin
                     count_q <= count_q + 16'd1;
                  end
               end
            end
            ARB_ERR: begin
               state_q <= ARB_DRAIN;
            end
            ARB_DRAIN: begin
               if (!grantCyc) begin
                  grant_q <= '0;
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               count_q <= '0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   // Bus routing. Only BUSY connects a master to the fabric; every other
   // state (including reset) presents an idle slave bus and no responses,
   // except the single forced-error cycle in ERR.
   always_comb begin
      o_slv_cyc = 1'b0;
      o_slv_stb = 1'b0;
      o_slv_we  = 1'b0;
      o_slv_adr = '0;
      o_slv_dat = '0;
      o_slv_sel = '0;
      o_slv_cti = '0;
      o_mst_ack = '0;
      o_mst_err = '0;
      o_mst_dat = '0;
      if (state_q == ARB_BUSY) begin
         for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
               o_slv_cyc = i_mst_cyc[k];
               o_slv_stb = i_mst_stb[k];
               o_slv_we  = i_mst_we[k];
               o_slv_adr = i_mst_adr[k*32 +: 32];
               o_slv_dat = i_mst_dat[k*32 +: 32];
               o_slv_sel = i_mst_sel[k*4 +: 4];
               o_slv_cti = i_mst_cti[k*3 +: 3];
            end
         end
         o_mst_ack = grant_q & {NUM_MASTERS{i_slv_ack}};
         o_mst_err = grant_q & {NUM_MASTERS{i_slv_err}};
         o_mst_dat = i_slv_dat;
      end else if (state_q == ARB_ERR) begin
         o_mst_err = grant_q;
      end
   end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb_zap_wb_arbiter
// Bench for zap_wb_arbiter with two masters and an 8-cycle watchdog.
// A transaction-level reference model (current owner, previous winner,
// stalled-beat count, error/drain flags) predicts every output each cycle;
// directed scenarios add explicit expectations for the key timing points.
module tb_zap_wb_arbiter;

   localparam int N  = 2;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rstN = 1'b0;
   logic [N-1:0]    mCyc, mStb, mWe;
   logic [32*N-1:0] mAdr, mDatW;
   logic [4*N-1:0]  mSel;
   logic [3*N-1:0]  mCti;
   logic            slvAck, slvErr;
   logic [31:0]     slvDat;

   logic [N-1:0]    oMstAck, oMstErr, oGrant;
   logic [31:0]     oMstDat, oSlvAdr, oSlvDat;
   logic            oSlvCyc, oSlvStb, oSlvWe, oTimeout;
   logic [3:0]      oSlvSel;
   logic [2:0]      oSlvCti;

   int checks = 0;
   int errors = 0;
   int ack0Seen = 0;

   // Reference model state
   int owner;
   int lastW;
   int stall;
   bit inErr;
   bit draining;

   zap_wb_arbiter #(
      .NUM_MASTERS (N),
      .TIMEOUT     (TO)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rstN),
      .i_mst_cyc (mCyc),
      .i_mst_stb (mStb),
      .i_mst_we  (mWe),
      .i_mst_adr (mAdr),
      .i_mst_dat (mDatW),
      .i_mst_sel (mSel),
      .i_mst_cti (mCti),
      .o_mst_ack (oMstAck),
      .o_mst_err (oMstErr),
      .o_mst_dat (oMstDat),
      .o_slv_cyc (oSlvCyc),
      .o_slv_stb (oSlvStb),
      .o_slv_we  (oSlvWe),
      .o_slv_adr (oSlvAdr),
      .o_slv_dat (oSlvDat),
      .o_slv_sel (oSlvSel),
      .o_slv_cti (oSlvCti),
      .i_slv_ack (slvAck),
      .i_slv_err (slvErr),
      .i_slv_dat (slvDat),
      .o_grant   (oGrant),
      .o_timeout (oTimeout)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic modelReset();
      owner    = -1;
      lastW    = N - 1;
      stall    = 0;
      inErr    = 1'b0;
      draining = 1'b0;
   endtask

   task automatic clearInputs();
      mCyc = '0; mStb = '0; mWe = '0;
      mAdr = '0; mDatW = '0; mSel = '0; mCti = '0;
      slvAck = 1'b0; slvErr = 1'b0; slvDat = '0;
   endtask

   // One clock cycle: compare outputs against the model at the falling
   // edge, advance the model with the same inputs, then step past the
   // rising edge so the caller can drive the next cycle.
   task automatic applyStimulus();
      logic [N-1:0] eGrant, eAck, eErr;
      logic         eCyc, eStb, eTo;
      bit           busy;
      @(negedge clk);
      eGrant = '0; eAck = '0; eErr = '0;
      eCyc = 1'b0; eStb = 1'b0; eTo = 1'b0;
      busy = (owner >= 0) && !inErr && !draining;
      if (owner >= 0) eGrant[owner] = 1'b1;
      if (busy) begin
         eCyc = mCyc[owner];
         eStb = mStb[owner];
         if (slvAck) eAck[owner] = 1'b1;
         if (slvErr) eErr[owner] = 1'b1;
      end
      if (inErr) begin
         eErr[owner] = 1'b1;
         eTo = 1'b1;
      end
      checkOutput("grant", oGrant, eGrant);
      checkOutput("slv_cyc", oSlvCyc, eCyc);
      checkOutput("slv_stb", oSlvStb, eStb);
      checkOutput("mst_ack", oMstAck, eAck);
      checkOutput("mst_err", oMstErr, eErr);
      checkOutput("timeout", oTimeout, eTo);
      if (busy) begin
         checkOutput("slv_adr", oSlvAdr, mAdr[owner*32 +: 32]);
         checkOutput("slv_dat", oSlvDat, mDatW[owner*32 +: 32]);
         checkOutput("slv_sel", oSlvSel, mSel[owner*4 +: 4]);
         checkOutput("slv_cti", oSlvCti, mCti[owner*3 +: 3]);
         checkOutput("slv_we", oSlvWe, mWe[owner]);
         checkOutput("mst_dat", oMstDat, slvDat);
      end
      if (oMstAck[0]) ack0Seen++;

      if (owner < 0) begin
         if (mCyc != '0) begin
            for (int i = 1; i <= N; i++) begin
               if (owner < 0 && mCyc[(lastW + i) % N]) owner = (lastW + i) % N;
            end
            lastW = owner;
            stall = 0;
         end
      end else if (inErr) begin
         inErr    = 1'b0;
         draining = 1'b1;
      end else if (draining) begin
         if (!mCyc[owner]) begin
            owner    = -1;
            draining = 1'b0;
         end
      end else begin
         if (!mCyc[owner]) begin
            owner = -1;
         end else if (slvAck || slvErr) begin
            stall = 0;
         end else if (mStb[owner]) begin
            stall++;
            if (stall == TO) begin
               inErr = 1'b1;
               stall = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rstN = 1'b0;
      clearInputs();
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   // Random master and slave behaviour state
   int remain [N];
   int slvStall;

   initial begin
      clearInputs();
      modelReset();

      // Reset state: outputs silent even with requests and slave activity
      mCyc = 2'b11; mStb = 2'b11; slvAck = 1'b1; slvErr = 1'b1; slvDat = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      checkOutput("rst_grant", oGrant, 2'b00);
      checkOutput("rst_slv_cyc", oSlvCyc, 1'b0);
      checkOutput("rst_mst_ack", oMstAck, 2'b00);
      checkOutput("rst_mst_err", oMstErr, 2'b00);
      checkOutput("rst_mst_dat", oMstDat, 32'h0);
      checkOutput("rst_timeout", oTimeout, 1'b0);
      resetDut();

      // Single CPU classic read, ack two cycles after grant
      ack0Seen = 0;
      mCyc[0] = 1'b1; mStb[0] = 1'b1; mAdr[31:0] = 32'h0000_0100;
      mSel[3:0] = 4'hF; mCti[2:0] = 3'b000;
      #1 checkOutput("t1_grant_pre", oGrant, 2'b00);
      applyStimulus();
      checkOutput("t1_grant", oGrant, 2'b01);
      checkOutput("t1_slv_adr", oSlvAdr, 32'h0000_0100);
      applyStimulus();
      applyStimulus();
      slvAck = 1'b1; slvDat = 32'hDEADBEEF;
      #1 checkOutput("t1_ack", oMstAck, 2'b01);
      checkOutput("t1_dat", oMstDat, 32'hDEADBEEF);
      applyStimulus();
      slvAck = 1'b0; mCyc[0] = 1'b0; mStb[0] = 1'b0;
      applyStimulus();
      checkOutput("t1_grant_rel", oGrant, 2'b00);
      applyStimulus();
      checkOutput("t1_ack_count", ack0Seen, 1);

      // Both masters request from reset: grants alternate 0,1,0,1...
      resetDut();
      mCyc = 2'b11; mStb = 2'b11;
      for (int txn = 0; txn < 8; txn++) begin
         int guard;
         int g;
         guard = 0;
         g = txn % 2;
         while (oGrant == '0 && guard < 6) begin
            applyStimulus();
            guard++;
         end
         checkOutput("t2_order", oGrant, (g == 0) ? 2'b01 : 2'b10);
         slvAck = 1'b1;
         applyStimulus();
         slvAck = 1'b0; mCyc[g] = 1'b0; mStb[g] = 1'b0;
         applyStimulus();
         mCyc[g] = 1'b1; mStb[g] = 1'b1;
      end
      mCyc = '0; mStb = '0;
      applyStimulus();
      applyStimulus();

      // EthMAC 4-beat INCR burst; CPU requests mid-burst and must wait
      mCyc[1] = 1'b1; mStb[1] = 1'b1; mSel[7:4] = 4'hF; mCti[5:3] = 3'b010;
      mAdr[63:32] = 32'h0000_2000;
      applyStimulus();
      for (int b = 0; b < 4; b++) begin
         mCti[5:3] = (b == 3) ? 3'b111 : 3'b010;
         mAdr[63:32] = 32'h0000_2000 + 32'(4 * b);
         slvAck = 1'b1; slvDat = 32'hA000_0000 + 32'(b);
         if (b == 1) begin
            mCyc[0] = 1'b1; mStb[0] = 1'b1;
         end
         #1 checkOutput("t3_grant", oGrant, 2'b10);
         checkOutput("t3_ack", oMstAck, 2'b10);
         checkOutput("t3_cti", oSlvCti, (b == 3) ? 3'b111 : 3'b010);
         applyStimulus();
      end
      slvAck = 1'b0; mCyc[1] = 1'b0; mStb[1] = 1'b0;
      applyStimulus();
      checkOutput("t3_dead", oGrant, 2'b00);
      applyStimulus();
      checkOutput("t3_cpu_grant", oGrant, 2'b01);
      mCyc[0] = 1'b0; mStb[0] = 1'b0;
      applyStimulus();
      applyStimulus();

      // Watchdog: slave never acks, error exactly TO cycles after stb
      mCyc[0] = 1'b1; mStb[0] = 1'b1;
      applyStimulus();
      for (int c = 1; c <= TO; c++) begin
         checkOutput("t4_no_to", oTimeout, 1'b0);
         checkOutput("t4_slv_stb", oSlvStb, 1'b1);
         applyStimulus();
      end
      checkOutput("t4_timeout", oTimeout, 1'b1);
      checkOutput("t4_err", oMstErr, 2'b01);
      checkOutput("t4_slv_cyc", oSlvCyc, 1'b0);
      applyStimulus();
      for (int c = 0; c < 3; c++) begin
         checkOutput("t4_drain_grant", oGrant, 2'b01);
         checkOutput("t4_drain_err", oMstErr, 2'b00);
         checkOutput("t4_drain_to", oTimeout, 1'b0);
         slvAck = 1'b1;
         applyStimulus();
      end
      slvAck = 1'b0; mCyc[0] = 1'b0; mStb[0] = 1'b0;
      applyStimulus();
      checkOutput("t4_release", oGrant, 2'b00);
      applyStimulus();

      // Ack on the last watchdog cycle wins over the timeout
      mCyc[0] = 1'b1; mStb[0] = 1'b1;
      applyStimulus();
      for (int c = 1; c < TO; c++) applyStimulus();
      slvAck = 1'b1;
      #1 checkOutput("t5_ack", oMstAck, 2'b01);
      applyStimulus();
      slvAck = 1'b0;
      checkOutput("t5_no_to", oTimeout, 1'b0);
      checkOutput("t5_no_err", oMstErr, 2'b00);
      checkOutput("t5_still_busy", oSlvCyc, 1'b1);
      applyStimulus();
      mCyc[0] = 1'b0; mStb[0] = 1'b0;
      applyStimulus();
      applyStimulus();

      // Asynchronous reset mid-burst
      mCyc = 2'b11; mStb = 2'b11;
      applyStimulus();
      applyStimulus();
      slvAck = 1'b1; slvDat = 32'h1234_5678;
      #2 rstN = 1'b0;
      #1;
      checkOutput("t6_grant", oGrant, 2'b00);
      checkOutput("t6_slv_cyc", oSlvCyc, 1'b0);
      checkOutput("t6_slv_stb", oSlvStb, 1'b0);
      checkOutput("t6_slv_adr", oSlvAdr, 32'h0);
      checkOutput("t6_mst_ack", oMstAck, 2'b00);
      checkOutput("t6_mst_dat", oMstDat, 32'h0);
      modelReset();
      slvAck = 1'b0;
      @(posedge clk);
      #1 rstN = 1'b1;
      applyStimulus();
      checkOutput("t6_first_grant", oGrant, 2'b01);
      mCyc = '0; mStb = '0;
      applyStimulus();
      applyStimulus();

      // Randomised traffic against the reference model
      for (int m = 0; m < N; m++) remain[m] = 0;
      slvStall = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int m = 0; m < N; m++) begin
            if (remain[m] == 0) begin
               if (mCyc[m]) begin
                  mCyc[m] = 1'b0;
               end else if ($urandom_range(0, 3) == 0) begin
                  mCyc[m] = 1'b1;
                  remain[m] = $urandom_range(1, 20);
               end
            end else begin
               remain[m]--;
            end
            mStb[m] = mCyc[m] && ($urandom_range(0, 3) != 0);
            mWe[m] = 1'($urandom_range(0, 1));
            mAdr[m*32 +: 32] = $urandom;
            mDatW[m*32 +: 32] = $urandom;
            mSel[m*4 +: 4] = 4'($urandom_range(0, 15));
            mCti[m*3 +: 3] = 3'($urandom_range(0, 7));
         end
         if (slvStall > 0) begin
            slvStall--;
            slvAck = 1'b0;
            slvErr = 1'b0;
         end else begin
            int r;
            r = $urandom_range(0, 15);
            slvAck = (r < 5);
            slvErr = (r == 5);
            if (r == 15) slvStall = $urandom_range(5, 12);
         end
         slvDat = $urandom;
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
